// File: rtl/wb_pkg.sv
// Shared types and defaults for the writeback arbiter.
//   wb_src_e : write source code driven on reg_src_o
//   wb_req_t : default buffered-request layout (destination + data)
package wb_pkg;

    localparam int WB_ALU_FIFO_DEPTH = 2;
    localparam int WB_DATA_W         = 32;
    localparam int WB_ADDR_W         = 5;

    typedef enum logic [1:0] {
        WB_SRC_NONE = 2'd0,
        WB_SRC_ALU  = 2'd1,
        WB_SRC_MDU  = 2'd2,
        WB_SRC_LSU  = 2'd3
    } wb_src_e;

    typedef struct packed {
        logic [WB_ADDR_W-1:0] waddr;
        logic [WB_DATA_W-1:0] data;
    } wb_req_t;

endpackage

// File: rtl/wb_sync_fifo.sv
// Synchronous FIFO of writeback requests.
//   clk, rst_n : clock, synchronous active-low reset
//   push/wr_req: enqueue (ignored when full)
//   pop/rd_req : dequeue; rd_req is the current head (valid when !empty)
//   flush      : empties the FIFO at the clock edge, overrides push/pop
//   count/full/empty : registered occupancy
module wb_sync_fifo
    import wb_pkg::*;
#(
    parameter int  DEPTH = WB_ALU_FIFO_DEPTH,
    parameter type req_t = wb_req_t
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  req_t                       wr_req,
    input  logic                       pop,
    output req_t                       rd_req,
    input  logic                       flush,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    req_t             mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rd_req  = mem[rd_ptr];

    // DEPTH is a power of two, so pointers wrap by natural overflow.
    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset; occupancy alone defines validity.
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= wr_req;
    end

endmodule

// File: rtl/exu_wb_arb.sv
// Writeback arbiter: merges ALU, MDU and LSU results onto the single
// register-file write port through one output register stage.
//   alu_*          : ALU result, no handshake; alu_stall_o holds issue
//   mdu_*, lsu_*   : valid/ready result sources
//   flush_i        : squashes buffered and live ALU results
//   reg_*_o        : registered write port, reg_src_o = wb_src_e code
//   ovf_o          : sticky, ALU result arrived while stalled
module exu_wb_arb
    import wb_pkg::*;
#(
    parameter int ALU_FIFO_DEPTH = WB_ALU_FIFO_DEPTH,
    parameter int DATA_W         = WB_DATA_W,
    parameter int ADDR_W         = WB_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] alu_result_i,
    input  logic              alu_reg_we_i,
    input  logic [ADDR_W-1:0] alu_reg_waddr_i,
    output logic              alu_stall_o,
    input  logic              mdu_valid_i,
    input  logic [DATA_W-1:0] mdu_result_i,
    input  logic [ADDR_W-1:0] mdu_waddr_i,
    output logic              mdu_ready_o,
    input  logic              lsu_valid_i,
    input  logic [DATA_W-1:0] lsu_data_i,
    input  logic [ADDR_W-1:0] lsu_waddr_i,
    output logic              lsu_ready_o,
    input  logic              flush_i,
    output logic              reg_we_o,
    output logic [ADDR_W-1:0] reg_waddr_o,
    output logic [DATA_W-1:0] reg_wdata_o,
    output logic [1:0]        reg_src_o,
    output logic              ovf_o
);

    localparam int CNT_W = $clog2(ALU_FIFO_DEPTH+1);

    typedef struct packed {
        logic [ADDR_W-1:0] waddr;
        logic [DATA_W-1:0] data;
    } req_t;

    req_t             alu_req, mdu_req, lsu_req, fifo_head, grant_req;
    wb_src_e          grant_src, reg_src_q;
    logic [CNT_W-1:0] fifo_count;
    logic             fifo_full, fifo_empty;
    logic             fifo_push, fifo_pop;
    logic             alu_live, head_vld, full_pri, alu_bypass, grant_wr;

    assign alu_req = '{waddr: alu_reg_waddr_i, data: alu_result_i};
    assign mdu_req = '{waddr: mdu_waddr_i,     data: mdu_result_i};
    assign lsu_req = '{waddr: lsu_waddr_i,     data: lsu_data_i};

    assign alu_stall_o = (fifo_count == CNT_W'(ALU_FIFO_DEPTH));

    // A flush makes the FIFO look empty for this cycle's arbitration.
    assign alu_live = alu_reg_we_i && (alu_reg_waddr_i != '0) && !flush_i && !alu_stall_o;
    assign head_vld = !fifo_empty && !flush_i;
    assign full_pri = fifo_full && !flush_i;

    always_comb begin
        grant_src   = WB_SRC_NONE;
        grant_req   = '0;
        lsu_ready_o = 1'b0;
        mdu_ready_o = 1'b0;
        fifo_pop    = 1'b0;
        alu_bypass  = 1'b0;
        if (full_pri) begin
            // Full buffer drains first so the ALU is never starved.
            grant_src = WB_SRC_ALU;
            grant_req = fifo_head;
            fifo_pop  = 1'b1;
        end else if (lsu_valid_i) begin
            lsu_ready_o = 1'b1;
            grant_src   = WB_SRC_LSU;
            grant_req   = lsu_req;
        end else if (mdu_valid_i) begin
            mdu_ready_o = 1'b1;
            grant_src   = WB_SRC_MDU;
            grant_req   = mdu_req;
        end else if (head_vld) begin
            grant_src = WB_SRC_ALU;
            grant_req = fifo_head;
            fifo_pop  = 1'b1;
        end else if (alu_live) begin
            grant_src  = WB_SRC_ALU;
            grant_req  = alu_req;
            alu_bypass = 1'b1;
        end
    end

    // A live ALU result not sent straight out queues behind older entries.
    assign fifo_push = alu_live && !alu_bypass;

    // x0 targets are consumed but never written.
    assign grant_wr = (grant_src != WB_SRC_NONE) && (grant_req.waddr != '0);

    wb_sync_fifo #(
        .DEPTH (ALU_FIFO_DEPTH),
        .req_t (req_t)
    ) u_alu_fifo (
        .clk    (clk),
        .rst_n  (rst_n),
        .push   (fifo_push),
        .wr_req (alu_req),
        .pop    (fifo_pop),
        .rd_req (fifo_head),
        .flush  (flush_i),
        .count  (fifo_count),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            reg_we_o    <= 1'b0;
            reg_waddr_o <= '0;
            reg_wdata_o <= '0;
            reg_src_q   <= WB_SRC_NONE;
            ovf_o       <= 1'b0;
        end else begin
            reg_we_o  <= grant_wr;
            reg_src_q <= grant_wr ? grant_src : WB_SRC_NONE;
            if (grant_wr) begin
                reg_waddr_o <= grant_req.waddr;
                reg_wdata_o <= grant_req.data;
            end
            if (alu_reg_we_i && alu_stall_o && !flush_i) ovf_o <= 1'b1;
        end
    end

    assign reg_src_o = reg_src_q;

endmodule

// File: tb/tb_exu_wb_arb.sv
module tb_exu_wb_arb;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] alu_result;
    logic        alu_we;
    logic [4:0]  alu_waddr;
    logic        alu_stall;
    logic        mdu_valid;
    logic [31:0] mdu_result;
    logic [4:0]  mdu_waddr;
    logic        mdu_ready;
    logic        lsu_valid;
    logic [31:0] lsu_data;
    logic [4:0]  lsu_waddr;
    logic        lsu_ready;
    logic        flush;
    logic        reg_we;
    logic [4:0]  reg_waddr;
    logic [31:0] reg_wdata;
    logic [1:0]  reg_src;
    logic        ovf;

    int n_pass  = 0;
    int n_total = 0;

    // {we, waddr, wdata, src}
    logic [39:0] got;
    assign got = {reg_we, reg_waddr, reg_wdata, reg_src};

    always #5 clk = ~clk;

    exu_wb_arb dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .alu_result_i    (alu_result),
        .alu_reg_we_i    (alu_we),
        .alu_reg_waddr_i (alu_waddr),
        .alu_stall_o     (alu_stall),
        .mdu_valid_i     (mdu_valid),
        .mdu_result_i    (mdu_result),
        .mdu_waddr_i     (mdu_waddr),
        .mdu_ready_o     (mdu_ready),
        .lsu_valid_i     (lsu_valid),
        .lsu_data_i      (lsu_data),
        .lsu_waddr_i     (lsu_waddr),
        .lsu_ready_o     (lsu_ready),
        .flush_i         (flush),
        .reg_we_o        (reg_we),
        .reg_waddr_o     (reg_waddr),
        .reg_wdata_o     (reg_wdata),
        .reg_src_o       (reg_src),
        .ovf_o           (ovf)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        alu_we = 0; alu_waddr = 0; alu_result = 0;
        mdu_valid = 0; mdu_waddr = 0; mdu_result = 0;
        lsu_valid = 0; lsu_waddr = 0; lsu_data = 0;
        flush = 0;
    endtask

    task automatic set_alu(input logic [4:0] a, input logic [31:0] d);
        alu_we = 1; alu_waddr = a; alu_result = d;
    endtask

    task automatic set_lsu(input logic [4:0] a, input logic [31:0] d);
        lsu_valid = 1; lsu_waddr = a; lsu_data = d;
    endtask

    task automatic set_mdu(input logic [4:0] a, input logic [31:0] d);
        mdu_valid = 1; mdu_waddr = a; mdu_result = d;
    endtask

    task automatic do_reset();
        idle_in();
        rst_n = 0;
        tick();
        tick();
        rst_n = 1;
    endtask

    task automatic test_reset();
        do_reset();
        n_total++;
        if (got !== 40'h0) $display("FAIL reset_out: got %h want %h", got, 40'h0);
        else n_pass++;
        n_total++;
        if ({alu_stall, ovf} !== 2'b00) $display("FAIL reset_flags: got %b want 00", {alu_stall, ovf});
        else n_pass++;
    endtask

    task automatic test_alu_bypass();
        set_alu(5, 32'h1234);
        tick();
        idle_in();
        n_total++;
        if (got !== {1'b1, 5'd5, 32'h1234, 2'd1}) $display("FAIL alu_bypass: got %h want %h", got, {1'b1, 5'd5, 32'h1234, 2'd1});
        else n_pass++;
        n_total++;
        if (alu_stall !== 1'b0) $display("FAIL alu_bypass_stall: got %b want 0", alu_stall);
        else n_pass++;
        tick();
        // FIFO stayed empty: idle write, address/data held
        n_total++;
        if (got !== {1'b0, 5'd5, 32'h1234, 2'd0}) $display("FAIL alu_bypass_idle: got %h want %h", got, {1'b0, 5'd5, 32'h1234, 2'd0});
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        for (int i = 1; i <= 4; i++) begin
            set_alu(5'(i + 16), 32'hB000 + 32'(i));
            tick();
            n_total++;
            if (got !== {1'b1, 5'(i + 16), 32'hB000 + 32'(i), 2'd1})
                $display("FAIL b2b_alu_%0d: got %h want %h", i, got, {1'b1, 5'(i + 16), 32'hB000 + 32'(i), 2'd1});
            else n_pass++;
        end
        idle_in();
        tick();
    endtask

    task automatic test_lsu_collision();
        set_lsu(7, 32'hAAAA);
        set_alu(3, 32'h11);
        #1;
        n_total++;
        if (lsu_ready !== 1'b1) $display("FAIL coll_lsu_ready: got %b want 1", lsu_ready);
        else n_pass++;
        tick();
        idle_in();
        n_total++;
        if (got !== {1'b1, 5'd7, 32'hAAAA, 2'd3}) $display("FAIL coll_lsu: got %h want %h", got, {1'b1, 5'd7, 32'hAAAA, 2'd3});
        else n_pass++;
        tick();
        n_total++;
        if (got !== {1'b1, 5'd3, 32'h11, 2'd1}) $display("FAIL coll_alu: got %h want %h", got, {1'b1, 5'd3, 32'h11, 2'd1});
        else n_pass++;
        tick();
        n_total++;
        if (reg_we !== 1'b0) $display("FAIL coll_idle: got %b want 0", reg_we);
        else n_pass++;
    endtask

    task automatic test_fill_stall();
        set_lsu(10, 32'hB0);
        set_alu(1, 32'h101);
        tick();
        set_lsu(11, 32'hB1);
        set_alu(2, 32'h102);
        #1;
        n_total++;
        if (alu_stall !== 1'b0) $display("FAIL fill_stall_one: got %b want 0", alu_stall);
        else n_pass++;
        tick();
        n_total++;
        if (got !== {1'b1, 5'd11, 32'hB1, 2'd3}) $display("FAIL fill_lsu11: got %h want %h", got, {1'b1, 5'd11, 32'hB1, 2'd3});
        else n_pass++;
        set_lsu(12, 32'hB2);
        set_alu(3, 32'h103);
        #1;
        n_total++;
        if ({alu_stall, lsu_ready} !== 2'b10) $display("FAIL fill_full: got stall,lsu_ready=%b want 10", {alu_stall, lsu_ready});
        else n_pass++;
        tick();
        alu_we = 0; alu_waddr = 0; alu_result = 0;
        n_total++;
        if (got !== {1'b1, 5'd1, 32'h101, 2'd1}) $display("FAIL fill_alu1: got %h want %h", got, {1'b1, 5'd1, 32'h101, 2'd1});
        else n_pass++;
        n_total++;
        if (ovf !== 1'b1) $display("FAIL fill_ovf: got %b want 1", ovf);
        else n_pass++;
        #1;
        n_total++;
        if ({alu_stall, lsu_ready} !== 2'b01) $display("FAIL fill_drain: got stall,lsu_ready=%b want 01", {alu_stall, lsu_ready});
        else n_pass++;
        tick();
        idle_in();
        n_total++;
        if (got !== {1'b1, 5'd12, 32'hB2, 2'd3}) $display("FAIL fill_lsu12: got %h want %h", got, {1'b1, 5'd12, 32'hB2, 2'd3});
        else n_pass++;
        tick();
        n_total++;
        if (got !== {1'b1, 5'd2, 32'h102, 2'd1}) $display("FAIL fill_alu2: got %h want %h", got, {1'b1, 5'd2, 32'h102, 2'd1});
        else n_pass++;
        tick();
        // x3 was dropped
        n_total++;
        if ({reg_we, ovf} !== 2'b01) $display("FAIL fill_x3_dropped: got we,ovf=%b want 01", {reg_we, ovf});
        else n_pass++;
    endtask

    task automatic test_mdu_vs_lsu();
        set_lsu(20, 32'hC0);
        set_mdu(21, 32'hD0);
        #1;
        n_total++;
        if ({lsu_ready, mdu_ready} !== 2'b10) $display("FAIL mvl_ready1: got %b want 10", {lsu_ready, mdu_ready});
        else n_pass++;
        tick();
        lsu_valid = 0;
        #1;
        n_total++;
        if (mdu_ready !== 1'b1) $display("FAIL mvl_ready2: got %b want 1", mdu_ready);
        else n_pass++;
        n_total++;
        if (got !== {1'b1, 5'd20, 32'hC0, 2'd3}) $display("FAIL mvl_lsu: got %h want %h", got, {1'b1, 5'd20, 32'hC0, 2'd3});
        else n_pass++;
        tick();
        idle_in();
        n_total++;
        if (got !== {1'b1, 5'd21, 32'hD0, 2'd2}) $display("FAIL mvl_mdu: got %h want %h", got, {1'b1, 5'd21, 32'hD0, 2'd2});
        else n_pass++;
        // MDU beats a colliding ALU result, which follows next cycle
        set_mdu(8, 32'hE8);
        set_alu(9, 32'hE9);
        tick();
        idle_in();
        n_total++;
        if (got !== {1'b1, 5'd8, 32'hE8, 2'd2}) $display("FAIL mva_mdu: got %h want %h", got, {1'b1, 5'd8, 32'hE8, 2'd2});
        else n_pass++;
        tick();
        n_total++;
        if (got !== {1'b1, 5'd9, 32'hE9, 2'd1}) $display("FAIL mva_alu: got %h want %h", got, {1'b1, 5'd9, 32'hE9, 2'd1});
        else n_pass++;
        tick();
    endtask

    task automatic test_flush();
        do_reset();
        set_lsu(13, 32'hF1);
        set_alu(4, 32'h104);
        tick();
        set_lsu(14, 32'hF2);
        set_alu(5, 32'h105);
        tick();
        idle_in();
        #1;
        n_total++;
        if (alu_stall !== 1'b1) $display("FAIL flush_prefull: got %b want 1", alu_stall);
        else n_pass++;
        flush = 1;
        set_alu(9, 32'h999);
        tick();
        idle_in();
        n_total++;
        if ({reg_we, reg_src, alu_stall, ovf} !== 5'b0_00_0_0) $display("FAIL flush_after: got we,src,stall,ovf=%b want 00000", {reg_we, reg_src, alu_stall, ovf});
        else n_pass++;
        tick();
        tick();
        n_total++;
        if (got !== {1'b0, 5'd14, 32'hF2, 2'd0}) $display("FAIL flush_drained: got %h want %h", got, {1'b0, 5'd14, 32'hF2, 2'd0});
        else n_pass++;
    endtask

    task automatic test_x0();
        set_mdu(0, 32'hEE);
        #1;
        n_total++;
        if (mdu_ready !== 1'b1) $display("FAIL x0_mdu_ready: got %b want 1", mdu_ready);
        else n_pass++;
        tick();
        idle_in();
        n_total++;
        if (got !== {1'b0, 5'd14, 32'hF2, 2'd0}) $display("FAIL x0_mdu: got %h want %h", got, {1'b0, 5'd14, 32'hF2, 2'd0});
        else n_pass++;
        set_alu(0, 32'h77);
        tick();
        set_alu(0, 32'h78);
        tick();
        idle_in();
        tick();
        // ALU x0 neither written nor buffered
        n_total++;
        if ({reg_we, alu_stall} !== 2'b00) $display("FAIL x0_alu: got we,stall=%b want 00", {reg_we, alu_stall});
        else n_pass++;
    endtask

    task automatic test_reset_midop();
        set_lsu(15, 32'h55);
        set_alu(6, 32'h106);
        tick();
        idle_in();
        set_alu(7, 32'h107);
        rst_n = 0;
        tick();
        idle_in();
        n_total++;
        if ({got, alu_stall, ovf} !== 42'h0) $display("FAIL rst_mid_out: got %h want 0", {got, alu_stall, ovf});
        else n_pass++;
        rst_n = 1;
        tick();
        tick();
        n_total++;
        if (got !== 40'h0) $display("FAIL rst_mid_nobuf: got %h want 0", got);
        else n_pass++;
    endtask

    initial begin
        idle_in();
        rst_n = 0;
        test_reset();
        test_alu_bypass();
        test_back_to_back();
        test_lsu_collision();
        test_fill_stall();
        test_mdu_vs_lsu();
        test_flush();
        test_x0();
        test_reset_midop();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/exu_wb_arb.md
Name: exu_wb_arb

Overview:
Writeback arbiter directly downstream of the combinational ALU.
- Merges the ALU result (reg_we/waddr/result) with the multiply/divide unit (MDU) and load/store unit (LSU) results.
- Drives the single register-file write port through a registered stage.
- Buffers ALU results in a small FIFO when a higher-priority source holds the port, and stalls the ALU issue path when that FIFO is full.

Parameters:
ALU_FIFO_DEPTH, 2, ALU result buffer entries (power of two, ≥2)
DATA_W, 32, register data width
ADDR_W, 5, register address width

Ports:
clk  in  1  core clock
rst_n  in  1  synchronous active-low reset
alu_result_i  in  DATA_W  ALU result
alu_reg_we_i  in  1  ALU write request (one result per cycle, no handshake)
alu_reg_waddr_i  in  ADDR_W  ALU destination register
alu_stall_o  out  1  ALU FIFO full; issue must hold the next ALU op
mdu_valid_i  in  1  MDU result valid
mdu_result_i  in  DATA_W  MDU result
mdu_waddr_i  in  ADDR_W  MDU destination register
mdu_ready_o  out  1  MDU result accepted this cycle
lsu_valid_i  in  1  load data valid
lsu_data_i  in  DATA_W  load data
lsu_waddr_i  in  ADDR_W  load destination register
lsu_ready_o  out  1  load accepted this cycle
flush_i  in  1  interrupt/flush; squashes ALU results
reg_we_o  out  1  register-file write enable (registered)
reg_waddr_o  out  ADDR_W  write address (registered)
reg_wdata_o  out  DATA_W  write data (registered)
reg_src_o  out  2  source of current write: 0 none, 1 ALU, 2 MDU, 3 LSU (registered)
ovf_o  out  1  sticky: ALU write arrived while alu_stall_o=1

Behaviour:
- Reset (rst_n=0 at posedge): reg_we_o=0, reg_waddr_o=0, reg_wdata_o=0, reg_src_o=0, ovf_o=0, FIFO empty, alu_stall_o=0. Reset mid-operation discards all buffered results.
- Handshake: valid/ready per source. valid, data and waddr must hold until ready. Ready may depend combinationally on valid. A transfer completes on a cycle with valid & ready.
- Latency: a granted source appears on reg_*_o on the next cycle (1 cycle). An idle cycle gives reg_we_o=0 and reg_src_o=0; reg_wdata_o and reg_waddr_o keep their previous values.
- ALU candidate: FIFO head if the FIFO is non-empty, else the live ALU input (bypass). FIFO order is strictly preserved; bypass is allowed only when the FIFO is empty.
- Priority, normal: LSU > MDU > ALU candidate.
- Priority, FIFO full: ALU head > LSU > MDU. lsu_ready_o and mdu_ready_o are 0 that cycle. This provides anti-starvation.
- Unselected live ALU input (alu_reg_we_i=1, waddr≠0, not flushed) is pushed to the FIFO in the same cycle.
- Push and pop in the same cycle: count is unchanged; pointers wrap modulo ALU_FIFO_DEPTH.
- alu_stall_o = (count == ALU_FIFO_DEPTH), derived from registered count.
- If alu_reg_we_i=1 while alu_stall_o=1: the input is dropped and ovf_o is set. ovf_o clears only on reset.
- x0 writes: ALU writes to x0 are never pushed or granted. MDU/LSU writes to x0 are accepted (ready=1), but reg_we_o stays 0 and reg_src_o=0.
- flush_i=1:
  - FIFO is cleared at the clock edge.
  - The live ALU input is ignored.
  - No ALU grant that cycle.
  - MDU/LSU arbitration proceeds normally, using normal priority since the FIFO is treated as empty.
  - A flush in the same cycle as an overflow does not set ovf_o.
- Width: data passes through unmodified; no arithmetic.

Decomposition:
- Package wb_pkg holds:
  - wb_src_e enum: WB_SRC_NONE=0, WB_SRC_ALU=1, WB_SRC_MDU=2, WB_SRC_LSU=3.
  - wb_req_t struct {waddr, data}.
  - Default ALU_FIFO_DEPTH constant.
- Sub-module wb_sync_fifo: parameterised synchronous FIFO of wb_req_t with push/pop/flush/count/full/empty.
- Arbitration and output register stay in exu_wb_arb.

Test Plan:
- ALU-only bypass: alu_reg_we_i=1, waddr=5, result=0x1234 for one cycle → next cycle reg_we_o=1, reg_waddr_o=5, reg_wdata_o=0x1234, reg_src_o=1; FIFO stays empty.
- LSU collision: same cycle LSU valid waddr=7 data=0xAAAA and ALU waddr=3 data=0x11 → cycle+1 writes x7/0xAAAA (src 3); cycle+2 writes x3/0x11 (src 1).
- Fill and stall: LSU valid held 3 cycles while ALU writes x1,x2,x3 each cycle (DEPTH=2).
  - x1 and x2 are buffered; alu_stall_o=1 after two pushes.
  - x3 is presented while stalled → ovf_o=1, x3 is dropped.
  - Next grant is ALU x1 over LSU (full priority), lsu_ready_o=0 that cycle; then x2 in order.
- MDU vs LSU: both valid, FIFO empty → LSU granted first and MDU ready=0; MDU holds valid and is granted next cycle; values are checked.
- Flush: FIFO holds two entries and flush_i=1 with ALU input x9 → next cycle reg_we_o=0, alu_stall_o=0, count=0; x9 is never written.
- x0 and reset: MDU valid with waddr=0 → mdu_ready_o=1, reg_we_o=0. rst_n=0 with a non-empty FIFO → all outputs 0 and no buffered write after reset release.
